hwpe_ctrl_job_sched: RTL
========================

Name: hwpe_ctrl_job_sched

Overview:
- Job scheduler and context manager for the HWPE control register file.
- Arbitrates the offload lock between cores (acquire via test-and-set, release on trigger).
- Allocates job contexts as a circular queue and sequences the engine through queued jobs.
- Supplies the regfile flags: pointer/running context, full, critical, true done.
- Sits between the peripheral slave decode and the engine FSM.

Parameters:
N_CONTEXT, 2, number of job contexts (power of two, 2..4)
N_CORES, 8, number of requesters; one event line each
LOCK_TIMEOUT, 1024, cycles before a held lock is force-released (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
acquire_i  in  1  test-and-set read of the acquire register
acquire_id_i  in  $clog2(N_CORES)  requester id for acquire_i
trigger_i  in  1  write to the trigger register
trigger_id_i  in  $clog2(N_CORES)  requester id for trigger_i
grant_o  out  1  acquire accepted this cycle (combinational)
is_critical_o  out  1  lock held by some core
full_context_o  out  1  all contexts occupied
pointer_context_o  out  $clog2(N_CONTEXT)  context being programmed
running_context_o  out  $clog2(N_CONTEXT)  context executing or next to execute
n_jobs_o  out  $clog2(N_CONTEXT)+1  occupied contexts
start_o  out  1  one-cycle engine start pulse
engine_done_i  in  1  engine finished current job (one-cycle pulse)
true_done_o  out  1  one-cycle pulse, job retired
evt_o  out  N_CORES  one-hot done event to the owner of the retired job
trig_err_o  out  1  one-cycle pulse, illegal trigger ignored

Behaviour:
- Reset and clear_i: all outputs 0; lock FREE; scheduler IDLE; counters and pointers 0. clear_i has priority over every other input. Clear in RUN drops the job silently, with no true_done_o.
- Lock FSM:
  - FREE->HELD on acquire_i & ~full_context_o. grant_o=1 in the same cycle; owner latched from acquire_id_i.
  - acquire_i in HELD or while full: grant_o=0, state unchanged. The regfile encodes the response.
  - HELD->FREE on trigger_i with trigger_id_i==owner. The context at pointer_context_o is committed, its owner is stored in owner_q[pointer], pointer increments mod N_CONTEXT, and n_jobs increments.
  - trigger_i in FREE or from a non-owner: trig_err_o=1, no state change.
- is_critical_o = (lock==HELD). full_context_o = (n_jobs==N_CONTEXT).
- Scheduler FSM, states IDLE, START, RUN, DONE:
  - IDLE->START when n_jobs > number of jobs already started (i.e. a queued job exists).
  - START: start_o=1 for one cycle, then RUN.
  - RUN->DONE on engine_done_i.
  - DONE: true_done_o=1 and evt_o[owner_q[running]]=1 for one cycle. running increments mod N_CONTEXT, n_jobs decrements, then IDLE.
  - Minimum trigger->start_o latency is 2 cycles; done->next start_o is 2 cycles.
- n_jobs counts contexts from commit to retire, including the running job.
- Trigger commit and DONE retire in the same cycle: n_jobs unchanged; both pointers advance.
- Acquire while full is refused even if DONE frees a context in the same cycle (full evaluated on the registered count).
- Pointers wrap N_CONTEXT-1 -> 0.
- engine_done_i outside RUN is ignored.

Optional Feature:
- Macro HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN.
- Defined: a counter runs while HELD, reset on acquire. On reaching LOCK_TIMEOUT-1 the lock returns to FREE without committing a context, and trig_err_o pulses once.
- Not defined: the lock is held indefinitely until a legal trigger; no counter is instantiated.

Decomposition:
- Shared package hwpe_ctrl_package gains:
  - typedef sched_state_t {IDLE, START, RUN, DONE}
  - typedef lock_state_t {FREE, HELD}
  - constant SCHED_DEFAULT_LOCK_TIMEOUT
- One sub-module, hwpe_ctrl_ctx_fifo_ptr: wrap-around pointer pair plus occupancy counter with simultaneous push/pop, reused for the context queue.

Test Plan:
- Acquire id=3 at FREE -> grant_o=1 same cycle, is_critical_o=1. Then acquire id=5 -> grant_o=0. Trigger id=3 -> pointer_context_o 0->1, n_jobs_o=1, lock FREE.
- Single job: trigger at cycle t -> start_o at t+2. engine_done_i at t+10 -> true_done_o and evt_o=8'b0000_1000 at t+11, n_jobs_o=0, running_context_o=1.
- N_CONTEXT=2: two jobs committed with engine running -> full_context_o=1, third acquire refused. Retire -> full drops, next acquire granted, pointer wraps 1->0.
- Trigger at FREE, and trigger id=2 while owner=4 -> trig_err_o pulse, pointer and n_jobs unchanged.
- Trigger commit and DONE in the same cycle with n_jobs=1 -> n_jobs stays 1, both pointers advance. clear_i during RUN -> all outputs 0 next cycle, no true_done_o.
- With HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN, LOCK_TIMEOUT=16: acquire, no trigger -> lock FREE after 16 cycles, trig_err_o once, n_jobs_o=0.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared HWPE control types: scheduler/lock state encodings and default lock timeout.
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } sched_state_t;

    typedef enum logic {
        FREE,
        HELD
    } lock_state_t;

    localparam int unsigned SCHED_DEFAULT_LOCK_TIMEOUT = 1024;

endpackage

// File: rtl/hwpe_ctrl_job_sched_if.sv
// Regfile/engine-facing signals of the job scheduler; slave = scheduler, master = its drivers.
interface hwpe_ctrl_job_sched_if #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_CORES   = 8
);
    localparam int unsigned CW = $clog2(N_CONTEXT);
    localparam int unsigned IW = $clog2(N_CORES);

    logic              acquire_i;
    logic [IW-1:0]     acquire_id_i;
    logic              trigger_i;
    logic [IW-1:0]     trigger_id_i;
    logic              grant_o;
    logic              is_critical_o;
    logic              full_context_o;
    logic [CW-1:0]     pointer_context_o;
    logic [CW-1:0]     running_context_o;
    logic [CW:0]       n_jobs_o;
    logic              start_o;
    logic              engine_done_i;
    logic              true_done_o;
    logic [N_CORES-1:0] evt_o;
    logic              trig_err_o;

    modport slave (
        input  acquire_i, acquire_id_i, trigger_i, trigger_id_i, engine_done_i,
        output grant_o, is_critical_o, full_context_o, pointer_context_o,
               running_context_o, n_jobs_o, start_o, true_done_o, evt_o, trig_err_o
    );

    modport master (
        output acquire_i, acquire_id_i, trigger_i, trigger_id_i, engine_done_i,
        input  grant_o, is_critical_o, full_context_o, pointer_context_o,
               running_context_o, n_jobs_o, start_o, true_done_o, evt_o, trig_err_o
    );

endinterface

// File: rtl/hwpe_ctrl_ctx_fifo_ptr.sv
// Wrap-around write/read pointer pair with occupancy count; push and pop may coincide.
module hwpe_ctrl_ctx_fifo_ptr #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;

    // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
    always_comb begin
        wr_d    = push_i ? wr_q + PTR_ONE : wr_q;
        rd_d    = pop_i  ? rd_q + PTR_ONE : rd_q;
        count_d = count_q;
        if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
        else if (!push_i && pop_i) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign wr_ptr_o = wr_q;
    assign rd_ptr_o = rd_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_MAX);

endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// Offload lock arbitration plus circular job-context queue sequencing the engine.
// Optional lock watchdog enabled by defining HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN.
module hwpe_ctrl_job_sched
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT    = 2,
    parameter int unsigned N_CORES      = 8,
    parameter int unsigned LOCK_TIMEOUT = SCHED_DEFAULT_LOCK_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hwpe_ctrl_job_sched_if.slave  sched
);
    localparam int unsigned CW = $clog2(N_CONTEXT);
    localparam int unsigned IW = $clog2(N_CORES);

    lock_state_t  lock_q, lock_d;
    sched_state_t state_q, state_d;
    logic [IW-1:0] owner_id_q, owner_id_d;
    logic [N_CONTEXT-1:0][IW-1:0] ctx_owner_q;

    logic          grant, trig_ok, tmo_hit, full, pop;
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   n_jobs;
    logic [N_CORES-1:0] evt;

    // Full is judged on the registered count, so a same-cycle retire does not admit an acquire.
    assign grant   = sched.acquire_i && (lock_q == FREE) && !full && !clear_i;
    assign trig_ok = sched.trigger_i && (lock_q == HELD) &&
                     (sched.trigger_id_i == owner_id_q) && !clear_i;
    assign pop     = (state_q == DONE);

`ifdef HWPE_CTRL_SCHED_LOCK_TIMEOUT_EN
    localparam int unsigned TW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   tmo_cnt_q <= '0;
        else if (clear_i || grant || lock_q != HELD)   tmo_cnt_q <= '0;
        else                                           tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end

    // A legal trigger landing on the last cycle still wins over the watchdog.
    assign tmo_hit = (lock_q == HELD) && !trig_ok && !clear_i &&
                     (tmo_cnt_q == TW'(LOCK_TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        lock_d     = lock_q;
        owner_id_d = owner_id_q;
        if (grant) begin
            lock_d     = HELD;
            owner_id_d = sched.acquire_id_i;
        end else if (trig_ok || tmo_hit) begin
            lock_d = FREE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= FREE;
            owner_id_q <= '0;
        end else if (clear_i) begin
            lock_q     <= FREE;
            owner_id_q <= '0;
        end else begin
            lock_q     <= lock_d;
            owner_id_q <= owner_id_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ctx_owner_q         <= '0;
        else if (trig_ok) ctx_owner_q[wr_ptr] <= owner_id_q;
    end

    hwpe_ctrl_ctx_fifo_ptr #(.DEPTH(N_CONTEXT)) i_ctx_ptr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .push_i   (trig_ok),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (n_jobs),
        .full_o   (full)
    );

    // Only one job is ever in flight, so in IDLE any occupied context is a queued job.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (n_jobs != '0) state_d = START;
            START:   state_d = RUN;
            RUN:     if (sched.engine_done_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        evt = '0;
        if (state_q == DONE) evt[ctx_owner_q[rd_ptr]] = 1'b1;
    end

    assign sched.grant_o           = grant;
    assign sched.trig_err_o        = !clear_i && ((sched.trigger_i && !trig_ok) || tmo_hit);
    assign sched.is_critical_o     = (lock_q == HELD);
    assign sched.full_context_o    = full;
    assign sched.pointer_context_o = wr_ptr;
    assign sched.running_context_o = rd_ptr;
    assign sched.n_jobs_o          = n_jobs;
    assign sched.start_o           = (state_q == START);
    assign sched.true_done_o       = (state_q == DONE);
    assign sched.evt_o             = evt;

endmodule
